serial_adder: RTL

Bit-serial WIDTH-bit adder that feeds operands LSB-first through one full_adder instance, holding the carry in a flip-flop between bits. Upstream it accepts an operand pair over a valid/ready handshake. Downstream it presents the registered sum and carry-out over valid/ready. It is the sequential, area-minimal companion to the ripple 8-bit adder: one full_adder plus registers instead of WIDTH full_adders.

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_adder_full_adder.sv | 14 +
 rtl/serial_adder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package serial_adder_pkg;

    localparam int unsigned SA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder: the single arithmetic slice of the serial adder.
// Ports: a, b, cin (operand bits and carry in); sum_c, cout_c (combinational sum and carry out).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum_c,
    output logic cout_c
);

    assign sum_c  = a ^ b ^ cin;
    assign cout_c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB-first through one full_adder,
// with the carry held in a flop between bits.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready, in_a, in_b, in_cin   operand-pair handshake (sampled at accept only)
//   out_valid/out_ready, out_sum, out_cout  registered result handshake
//   busy                           high while shifting or holding a result
// Optional: define SERIAL_ADDER_OVF_EN to add out_ovf (two's-complement overflow).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             out_ovf,
`endif
    output logic             busy
);

    localparam int unsigned       CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic [WIDTH-1:0]   res_nxt;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               fa_sum;
    logic               fa_cout;
    logic               load_en;
    logic               shift_en;
    logic               last_bit;

    // Single bit slice working on the current LSBs and the held carry.
    full_adder u_fa (
        .a      (a_sr[0]),
        .b      (b_sr[0]),
        .cin    (carry),
        .sum_c  (fa_sum),
        .cout_c (fa_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 has reached the LSB.
    assign res_nxt = WIDTH'({fa_sum, res_sr} >> 1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath enables.
    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        shift_en  = 1'b0;
        last_bit  = (cnt == CNT_LAST);
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    load_en   = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (last_bit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand/result shift registers, carry, bit counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else if (load_en) begin
            a_sr   <= in_a;
            b_sr   <= in_b;
            res_sr <= '0;
            carry  <= in_cin;
            cnt    <= '0;
        end else if (shift_en) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_nxt;
            carry  <= fa_cout;
            cnt    <= cnt + CNT_W'(1);
            if (last_bit) begin
                out_sum  <= res_nxt;
                out_cout <= fa_cout;
            end
        end
    end

    // Handshake and status flags, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == ST_IDLE);
            out_valid <= (state_nxt == ST_DONE);
            busy      <= (state_nxt != ST_IDLE);
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ovf <= 1'b0;
        end else if (shift_en && last_bit) begin
            out_ovf <= carry ^ fa_cout;
        end
    end
`endif

endmodule
